// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_display
// Brief    : Four-digit multiplexed 7-segment driver, pattern or BCD step-count view
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_display #(
  parameter int REFRESH_DIV  = 50_000,
  parameter int BLANK_CYCLES = 500,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pattern_in,
  input  logic       step,
  input  logic       mode,
  input  logic       count_clr,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int              SC_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SC_W-1:0] c_sc_last = SC_W'(REFRESH_DIV - 1);
  localparam logic [SC_W-1:0] c_blank   = SC_W'(BLANK_CYCLES);
  localparam logic            c_inv     = (ACTIVE_LOW != 0);

  logic            step_prev_q;
  logic [15:0]     bcd_q, bcd_d, bcd_inc;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      snap_pat_q;
  logic            snap_mode_q;
  logic [15:0]     snap_bcd_q;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            w_step_rise;
  logic            w_sc_wrap;
  logic            w_frame_start;
  logic            w_lit;
  logic [3:0]      w_digit;
  logic            w_carry;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign w_step_rise   = step & ~step_prev_q;
  assign w_sc_wrap     = (sc_q == c_sc_last);
  assign w_frame_start = (sc_q == '0) && (idx_q == 2'd0);
  assign w_lit         = (sc_q >= c_blank);

  // Ripple BCD increment; a digit at 9 rolls to 0 and passes the carry on.
  always_comb begin
    bcd_inc = bcd_q;
    w_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          w_carry           = 1'b0;
        end
      end
    end
  end

  always_comb begin
    bcd_d = bcd_q;
    if (count_clr) begin
      bcd_d = '0;
    end else if (w_step_rise) begin
      bcd_d = bcd_inc;
    end
  end

  always_comb begin
    sc_d  = w_sc_wrap ? '0 : sc_q + 1'b1;
    idx_d = w_sc_wrap ? idx_q + 2'd1 : idx_q;
  end

  always_comb begin
    w_digit = snap_mode_q ? snap_bcd_q[4*idx_q +: 4] : {3'b000, snap_pat_q[idx_q]};
    an_d    = {4{c_inv}};
    seg_d   = {7{c_inv}};
    dp_d    = c_inv;
    if (w_lit) begin
      an_d  = (4'b0001 << idx_q) ^ {4{c_inv}};
      seg_d = glyph(w_digit) ^ {7{c_inv}};
      dp_d  = ((idx_q == 2'd0) && snap_mode_q) ^ c_inv;
    end
  end

  // step_prev tracks step even in reset so a level held across reset is not counted.
  always_ff @(posedge clk) begin
    step_prev_q <= step;
    if (rst) begin
      bcd_q       <= '0;
      sc_q        <= '0;
      idx_q       <= 2'd0;
      snap_pat_q  <= '0;
      snap_mode_q <= 1'b0;
      snap_bcd_q  <= '0;
      an_q        <= {4{c_inv}};
      seg_q       <= {7{c_inv}};
      dp_q        <= c_inv;
    end else begin
      bcd_q <= bcd_d;
      sc_q  <= sc_d;
      idx_q <= idx_d;
      if (w_frame_start) begin
        snap_pat_q  <= pattern_in;
        snap_mode_q <= mode;
        snap_bcd_q  <= bcd_q;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_display
// Brief    : Scoreboard bench; a time-based reference model predicts every output cycle
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_display;

  localparam int R = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pattern_in = 4'd0;
  logic       step = 1'b0;
  logic       mode = 1'b0;
  logic       count_clr = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_display #(
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pattern_in(pattern_in),
    .step      (step),
    .mode      (mode),
    .count_clr (count_clr),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  out_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: everything derives from the cycle count since reset release.
  int unsigned t = 0;
  int          cnt = 0;
  bit          prev = 1'b0;
  int          snap_cnt = 0;
  bit [3:0]    snap_pat = 4'd0;
  bit          snap_mode = 1'b0;
  int          gly[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  int          pow10[4] = '{1, 10, 100, 1000};

  always @(posedge clk) begin
    out_t e;
    int   slot, pos, dig;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (rst) begin
      t = 0; cnt = 0; snap_cnt = 0; snap_pat = 4'd0; snap_mode = 1'b0;
    end else begin
      slot = (t / R) % 4;
      pos  = t % R;
      if (t % (4 * R) == 0) begin
        snap_cnt  = cnt;
        snap_pat  = pattern_in;
        snap_mode = mode;
      end
      if (pos >= B) begin
        dig   = snap_mode ? (snap_cnt / pow10[slot]) % 10 : int'(snap_pat[slot]);
        e.an  = ~(4'b0001 << slot);
        e.seg = ~7'(gly[dig]);
        e.dp  = !(slot == 0 && snap_mode);
      end
      if (count_clr) cnt = 0;
      else if (step && !prev) cnt = (cnt + 1) % 10000;
      t++;
    end
    prev = step;
    q.push_back(e);
  end

  always @(negedge clk) begin
    out_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({an, seg, dp} !== e) begin
        errors++;
        $display("FAIL outputs t=%0d cnt=%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                 t, cnt, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_rst(input int n);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  task automatic pulse();
    step = 1'b1;
    cycles(1);
    step = 1'b0;
    cycles(1);
  endtask

  task automatic wait_t(input int unsigned n);
    int guard = 0;
    while (t != n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (t != n) begin
      errors++;
      $display("FAIL wait_t: reached t=%0d, wanted %0d", t, n);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs, step held high across release.
    cycles(1);
    for (int i = 0; i < 3; i++) begin
      pattern_in = 4'($urandom);
      mode       = 1'($urandom);
      count_clr  = 1'($urandom);
      step       = 1'b1;
      cycles(1);
    end
    pattern_in = 4'b1010; mode = 1'b0; count_clr = 1'b0;
    rst = 1'b0;
    cycles(4 * R * 2);
    step = 1'b0;
    mode = 1'b1;
    cycles(4 * R * 2);

    // Pattern view scan from reset.
    mode = 1'b0;
    do_rst(2);
    cycles(4 * R * 2);

    // Count view: 12 pulses, then a 5-cycle level adds one.
    do_rst(1);
    for (int i = 0; i < 12; i++) pulse();
    mode = 1'b1;
    cycles(4 * R * 2);
    step = 1'b1;
    cycles(5);
    step = 1'b0;
    cycles(4 * R * 2);

    // Wrap 9999 -> 0000.
    do_rst(1);
    for (int i = 0; i < 9999; i++) pulse();
    cycles(4 * R * 2);
    pulse();
    cycles(4 * R * 2);

    // Clear wins over a simultaneous edge at 0005.
    do_rst(1);
    for (int i = 0; i < 5; i++) pulse();
    cycles(4 * R);
    step = 1'b1; count_clr = 1'b1;
    cycles(1);
    step = 1'b0; count_clr = 1'b0;
    cycles(4 * R * 2);

    // Tear-free snapshot: pattern change during digit 1 LIT.
    mode = 1'b0; pattern_in = 4'b0000;
    do_rst(1);
    wait_t(R + B + 1);
    pattern_in = 4'b1111;
    cycles(4 * R * 2);

    // Reset mid-frame during digit 2 LIT with count 0037.
    mode = 1'b1;
    do_rst(1);
    for (int i = 0; i < 37; i++) pulse();
    wait_t(4 * R * 4);
    wait_t(4 * R * 5 + 2 * R + B + 2);
    do_rst(1);
    cycles(4 * R * 2);

    // Random traffic, including sporadic resets and clears.
    for (int i = 0; i < 3000; i++) begin
      pattern_in = 4'($urandom);
      step       = 1'($urandom);
      mode       = ($urandom_range(0, 63) == 0) ? ~mode : mode;
      count_clr  = ($urandom_range(0, 199) == 0);
      rst        = ($urandom_range(0, 499) == 0);
      cycles(1);
    end
    rst = 1'b0; count_clr = 1'b0; step = 1'b0;
    cycles(4 * R);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
